// File: rtl/pso_pkg.sv
// Shared types and constants for the power-shutoff sequencer.
// Sequence overhead excludes the on/off periods and the power-up wait.
package pso_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_GATE    = 3'd1,
        ST_SAVE    = 3'd2,
        ST_ISO     = 3'd3,
        ST_OFF     = 3'd4,
        ST_WAKE    = 3'd5,
        ST_RESTORE = 3'd6,
        ST_UNISO   = 3'd7
    } pso_state_e;

    localparam int unsigned SEQ_OVERHEAD_CYC = 5;

endpackage

// File: rtl/pso_dom_fsm.sv
// One switchable domain: shutdown/wake sequence FSM, shared period counter,
// power-up wait down-counter and saturating shutdown-event counter.
//
// state   | meaning
// RUN     | domain powered and clocked, counting on-period
// GATE    | clock gated
// SAVE    | retention save pulse
// ISO     | isolation raised
// OFF     | power switch open, counting off-period
// WAKE    | power restored, waiting for supply to settle
// RESTORE | retention restore pulse
// UNISO   | isolation dropped, clock still gated
module pso_dom_fsm
    import pso_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int PWR_UP_CYC = 4,
    parameter int EVT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             control_i,
    input  logic             test_mode_i,
    input  logic             off_req_i,
    input  logic [CNT_W-1:0] on_cyc_i,
    input  logic [CNT_W-1:0] off_cyc_i,
    output logic             clk_en_o,
    output logic             save_o,
    output logic             restore_o,
    output logic             iso_o,
    output logic             shutoff_o,
    output logic             dom_off_o,
    output logic [EVT_W-1:0] evt_cnt_o
);

    localparam int WK_W = (PWR_UP_CYC > 1) ? $clog2(PWR_UP_CYC) : 1;
    localparam logic [WK_W-1:0]  WK_LOAD = WK_W'(PWR_UP_CYC - 1);
    localparam logic [WK_W-1:0]  WK_ONE  = WK_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);

    pso_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WK_W-1:0]  wk_q, wk_d;
    logic [EVT_W-1:0] evt_q;
    logic [CNT_W-1:0] on_lim, off_lim;
    logic             auto_en;
    logic             clk_en_q, save_q, restore_q, iso_q, shutoff_q, dom_off_q;

    always_comb begin
        auto_en = control_i && !test_mode_i;
        // A zero period behaves like a one-cycle period.
        on_lim  = (on_cyc_i  == '0) ? '0 : on_cyc_i  - CNT_ONE;
        off_lim = (off_cyc_i == '0) ? '0 : off_cyc_i - CNT_ONE;
        state_d = state_q;
        cnt_d   = cnt_q;
        wk_d    = wk_q;
        case (state_q)
            ST_RUN: begin
                if ((auto_en && cnt_q >= on_lim) || (off_req_i && !test_mode_i)) begin
                    state_d = ST_GATE;
                    cnt_d   = '0;
                end else if (auto_en) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GATE: state_d = ST_SAVE;
            ST_SAVE: state_d = ST_ISO;
            ST_ISO: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
            ST_OFF: begin
                if (!auto_en || cnt_q >= off_lim) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                    wk_d    = WK_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAKE: begin
                if (wk_q == '0) state_d = ST_RESTORE;
                else            wk_d    = wk_q - WK_ONE;
            end
            ST_RESTORE: state_d = ST_UNISO;
            ST_UNISO: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            wk_q      <= '0;
            evt_q     <= '0;
            clk_en_q  <= 1'b1;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            iso_q     <= 1'b0;
            shutoff_q <= 1'b0;
            dom_off_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wk_q    <= wk_d;
            if (state_q == ST_ISO && evt_q != '1) evt_q <= evt_q + EVT_ONE;
            clk_en_q  <= (state_d == ST_RUN);
            save_q    <= (state_d == ST_SAVE);
            restore_q <= (state_d == ST_RESTORE);
            iso_q     <= (state_d inside {ST_ISO, ST_OFF, ST_WAKE, ST_RESTORE});
            shutoff_q <= (state_d == ST_OFF);
            dom_off_q <= (state_d != ST_RUN);
        end
    end

    assign clk_en_o  = clk_en_q;
    assign save_o    = save_q;
    assign restore_o = restore_q;
    assign iso_o     = iso_q;
    assign shutoff_o = shutoff_q;
    assign dom_off_o = dom_off_q;
    assign evt_cnt_o = evt_q;

endmodule

// File: rtl/pso_sequencer.sv
// Power-shutoff sequencer for N_DOM independent switchable domains; each
// domain runs its own periodic shutdown/wake sequence.
module pso_sequencer
    import pso_pkg::*;
#(
    parameter int N_DOM      = 3,
    parameter int CNT_W      = 16,
    parameter int PWR_UP_CYC = 4,
    parameter int EVT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   control,
    input  logic                   test_mode,
    input  logic [N_DOM*CNT_W-1:0] on_cyc,
    input  logic [N_DOM*CNT_W-1:0] off_cyc,
    input  logic [N_DOM-1:0]       off_req,
    output logic [N_DOM-1:0]       clk_en,
    output logic [N_DOM-1:0]       save,
    output logic [N_DOM-1:0]       restore,
    output logic [N_DOM-1:0]       iso,
    output logic [N_DOM-1:0]       shutoff,
    output logic [N_DOM-1:0]       dom_off,
    output logic [N_DOM*EVT_W-1:0] evt_cnt
);

    for (genvar d = 0; d < N_DOM; d++) begin : g_dom
        pso_dom_fsm #(
            .CNT_W      (CNT_W),
            .PWR_UP_CYC (PWR_UP_CYC),
            .EVT_W      (EVT_W)
        ) u_dom (
            .clk_i       (clk),
            .rst_n_i     (rst),
            .control_i   (control),
            .test_mode_i (test_mode),
            .off_req_i   (off_req[d]),
            .on_cyc_i    (on_cyc[d*CNT_W +: CNT_W]),
            .off_cyc_i   (off_cyc[d*CNT_W +: CNT_W]),
            .clk_en_o    (clk_en[d]),
            .save_o      (save[d]),
            .restore_o   (restore[d]),
            .iso_o       (iso[d]),
            .shutoff_o   (shutoff[d]),
            .dom_off_o   (dom_off[d]),
            .evt_cnt_o   (evt_cnt[d*EVT_W +: EVT_W])
        );
    end

endmodule

// File: doc/pso_sequencer.md
Name: pso_sequencer

Overview:
- Synthesizable, parametrised power-shutoff sequencer for N switchable domains, each with its own on/off period.
- Successor to the fixed single-shutoff, free-running-period scheme currently used for the MV_Demo power domains (vdd_A, vdd_B, vdd_D).
- Per domain, it generates the full ordered sequence: clock-gate, retention save, isolation, shutoff, power-up wait, restore, de-isolation.
- Sits beside the core, driving the power-switch, isolation and retention controls; a global `control` enable and `test_mode` override match the chip top.

Parameters:
- N_DOM, 3, number of switchable domains.
- CNT_W, 16, width of the period counters and of the per-domain on_cyc/off_cyc fields.
- PWR_UP_CYC, 4, cycles held in WAKE after shutoff deasserts, before restore (>=1).
- EVT_W, 8, width of the saturating per-domain shutdown-event counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- control  in  1  global enable; 0 = no automatic shutdowns, and any OFF domain wakes.
- test_mode  in  1  1 = force every domain on (same effect as control=0); also blocks off_req.
- on_cyc  in  N_DOM*CNT_W  per-domain RUN length in cycles; slice d = bits [d*CNT_W +: CNT_W].
- off_cyc  in  N_DOM*CNT_W  per-domain OFF length in cycles.
- off_req  in  N_DOM  per-domain immediate shutdown request, level, honoured only in RUN.
- clk_en  out  N_DOM  per-domain clock enable.
- save  out  N_DOM  one-cycle retention-save pulse.
- restore  out  N_DOM  one-cycle retention-restore pulse.
- iso  out  N_DOM  isolation enable.
- shutoff  out  N_DOM  power-switch off, 1 = domain unpowered.
- dom_off  out  N_DOM  1 in any state other than RUN.
- evt_cnt  out  N_DOM*EVT_W  per-domain count of entries into OFF; saturates at all-ones.

Behaviour:
- Reset (rst=0, async): every domain in RUN.
  - clk_en=all 1; save, restore, iso, shutoff and dom_off = all 0.
  - Period counters = 0; evt_cnt = 0.
  - Reset asserted mid-sequence forces RUN immediately; no save or restore pulse is emitted.
- Domains are fully independent; all outputs are registered.
- States are listed below as: outputs, duration, next state.
  - RUN: clk_en=1, iso=0, shutoff=0.
    - Counter increments each cycle while control=1 and test_mode=0; otherwise it holds.
    - Exit to GATE when cnt==max(on_cyc,1)-1 with control=1 and test_mode=0, or when off_req=1 with test_mode=0.
    - Expiry and off_req in the same cycle produce a single shutdown.
  - GATE: clk_en=0. 1 cycle, then SAVE.
  - SAVE: clk_en=0, save=1. 1 cycle, then ISO.
  - ISO: clk_en=0, iso=1. 1 cycle, then OFF.
  - OFF: iso=1, shutoff=1.
    - evt_cnt increments by 1 on entry.
    - Counter counts from 0; exit to WAKE when cnt==max(off_cyc,1)-1.
    - Exit to WAKE on the next edge if control=0 or test_mode=1.
  - WAKE: iso=1, shutoff=0. PWR_UP_CYC cycles, then RESTORE.
  - RESTORE: iso=1, restore=1. 1 cycle, then UNISO.
  - UNISO: iso=0, clk_en=0. 1 cycle, then RUN with counter=0.
- Invariants:
  - shutoff=1 implies iso=1 and clk_en=0.
  - save and restore are never high together, and never high while shutoff=1.
- Period sampling:
  - on_cyc slice is sampled on every RUN cycle; off_cyc slice on every OFF cycle.
  - A mid-period change takes effect on the next compare.
  - If the counter already exceeds the new limit, the next cycle exits.
- Once GATE is entered, the sequence always runs to completion through OFF.
  - control=0 or test_mode=1 only shortens OFF; it never aborts GATE, SAVE or ISO.
- Full cycle time for one automatic period: on + 3 + off + PWR_UP_CYC + 2 cycles.

Decomposition:
- Package pso_pkg holds:
  - the state enum (RUN, GATE, SAVE, ISO, OFF, WAKE, RESTORE, UNISO) as a 3-bit encoding;
  - a localparam for the sequence-overhead constant (5 cycles excluding PWR_UP_CYC).
- Sub-module pso_dom_fsm contains one domain's FSM, period counter, wake counter and evt_cnt.
- pso_sequencer instantiates pso_dom_fsm N_DOM times in a generate loop and slices the buses.

Test Plan:
- Basic period: N_DOM=3, PWR_UP_CYC=4, on=10, off=5, control=1 from reset release.
  - clk_en falls at cycle 10, save=1 at cycle 11, iso rises at cycle 12.
  - shutoff high during cycles 13-17, restore=1 at cycle 22, clk_en rises at cycle 24.
  - The sequence repeats every 24 cycles and evt_cnt increments once per period.
- Independence: domains set to on=10/20/30, off=5.
  - Each domain's shutoff edges match its own schedule; the other domains are unaffected.
- Override: test_mode=1 during OFF.
  - shutoff falls on the next edge, then WAKE 4 cycles, RESTORE, UNISO, RUN.
  - No further shutdowns occur while test_mode=1, and off_req is ignored.
- Request: off_req[1]=1 at RUN cycle 3 with control=0.
  - GATE on the next edge; OFF exits after 1 cycle because control=0.
  - evt_cnt[1]=1.
- Zero/limits: on_cyc=0 gives RUN lasting exactly 1 cycle. evt_cnt, driven past 255 events with EVT_W=8, stays at 255.
- Reset mid-OFF: rst=0 asynchronously while shutoff=1.
  - All outputs return to their reset values immediately; no restore pulse.
  - After release the domain resumes from a fresh RUN.
